// File: rtl/sha256_digest_uart_tx_if.sv
// Digest handshake bundle: the producer offers a 256-bit digest,
// the transmitter signals when it can take one.
interface sha256_digest_uart_tx_if;
  logic         digest_valid;
  logic [255:0] digest;
  logic         digest_ready;

  modport master (output digest_valid, output digest, input digest_ready);
  modport slave  (input digest_valid, input digest, output digest_ready);
endinterface

// File: rtl/sha256_digest_uart_tx.sv
// Serialises a 256-bit digest over a UART line as 32 bytes, 8N1,
// most significant byte first, each byte LSB first.
module sha256_digest_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                           clk,
  input  logic                           rst,
  sha256_digest_uart_tx_if.slave         bus,
  output logic                           uart_tx,
  output logic                           busy,
  output logic                           done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [255:0]       shreg;
  logic [BAUD_W-1:0]  baud;
  logic [2:0]         bit_cnt;
  logic [4:0]         byte_cnt;
  logic               ready;
  logic               baud_end;
  logic [7:0]         cur_byte;

  // The byte on the wire is always the top byte; it is shifted out after its stop bit.
  assign cur_byte         = shreg[255:248];
  assign baud_end         = (baud == BAUD_LAST);
  assign bus.digest_ready = ready;

  // Transmit FSM with registered line, status and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      baud     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state != IDLE && !baud_end) baud <= baud + BAUD_W'(1);
      case (state)
        IDLE: begin
          if (bus.digest_valid) begin
            shreg    <= bus.digest;
            state    <= START;
            baud     <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            uart_tx  <= 1'b0;
            busy     <= 1'b1;
            ready    <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            uart_tx <= cur_byte[0];
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              uart_tx <= cur_byte[bit_cnt + 3'd1];
            end
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (byte_cnt == 5'd31) begin
              // Last stop bit ends: back to idle, ready for the next digest this cycle.
              state   <= IDLE;
              uart_tx <= 1'b1;
              busy    <= 1'b0;
              ready   <= 1'b1;
              done    <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 5'd1;
              shreg    <= {shreg[247:0], 8'h00};
              state    <= START;
              uart_tx  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_digest_uart_tx.sv
// Directed bench for sha256_digest_uart_tx at 4 clocks per bit, with a
// UART decoder checking received bytes against a queue of expected bytes.
module tb_sha256_digest_uart_tx;

  localparam int CPB = 4;
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ONE = 256'h1;
  localparam logic [255:0] DB  = 256'h00112233445566778899aabbccddeeff0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic clk = 1'b0;
  logic rst;
  logic uart_tx, busy, done;

  sha256_digest_uart_tx_if dif ();

  sha256_digest_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (dif),
    .uart_tx (uart_tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rx_count = 0;
  logic [7:0] exp_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART decoder: sample each bit in the middle of its 4-cycle window.
  initial begin
    bit active = 0;
    int mcnt = 0;
    logic [7:0] rx_byte = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else if (!active) begin
        if (uart_tx === 1'b0) begin
          active = 1;
          mcnt = 0;
        end
      end else begin
        mcnt++;
        if (mcnt >= 6 && mcnt <= 34 && (mcnt % 4) == 2) rx_byte[(mcnt - 6) / 4] = uart_tx;
        if (mcnt == 38) begin
          chk("rx_stop", uart_tx, 1);
          if (exp_q.size() == 0) chk("rx_expected_avail", exp_q.size(), 1);
          else chk("rx_byte", rx_byte, exp_q.pop_front());
          rx_count++;
          active = 0;
        end
      end
    end
  end

  task automatic push_digest(input logic [255:0] d);
    for (int i = 0; i < 32; i++) exp_q.push_back(d[255 - 8*i -: 8]);
  endtask

  // Offer d until accepted; hs is the cycle number of the handshake edge.
  task automatic send(input logic [255:0] d, input bit keep, output int hs);
    @(posedge clk); #1;
    dif.digest_valid = 1'b1;
    dif.digest = d;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (dif.digest_ready) break;
    end
    chk("ready_seen", dif.digest_ready, 1);
    @(posedge clk); #1;
    hs = cyc;
    push_digest(d);
    if (!keep) dif.digest_valid = 1'b0;
  endtask

  task automatic wait_done(input bit watch_ready, output int dcyc, output bit ready_seen);
    ready_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) break;
      if (watch_ready && dif.digest_ready) ready_seen = 1;
    end
    chk("done_seen", done, 1);
    dcyc = cyc;
  endtask

  initial begin
    int hs, hs2, dc, dc2;
    bit rs, flag_done, flag_tx;
    logic [7:0] b0;
    logic exp_bit;

    // Reset, with a digest offered at the same time: it must not be taken.
    rst = 1'b1;
    dif.digest_valid = 1'b1;
    dif.digest = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_ready", dif.digest_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dif.digest_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_capture_busy", busy, 0);
    chk("rst_no_capture_tx", uart_tx, 1);

    // "abc" digest: exact first frame, then an all-FF digest offered while busy.
    rx_count = 0;
    send(ABC, 0, hs);
    b0 = ABC[255:248];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 4) exp_bit = 1'b0;
      else if (k < 36) exp_bit = b0[(k - 4) / 4];
      else exp_bit = 1'b1;
      chk($sformatf("frame0_k%0d", k), uart_tx, exp_bit);
    end
    chk("busy_in_transfer", busy, 1);
    dif.digest_valid = 1'b1;
    dif.digest = '1;
    wait_done(1, dc, rs);
    dif.digest_valid = 1'b0;
    chk("ready_low_while_busy", rs, 0);
    chk("abc_latency", dc - hs, 320 * CPB);
    chk("ready_in_done_cycle", dif.digest_ready, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ff_not_taken", busy, 0);
    repeat (4) @(negedge clk);
    chk("abc_rx_count", rx_count, 32);
    chk("abc_queue_drained", exp_q.size(), 0);

    // Reset during DATA of byte 5, then a fresh digest from byte 0.
    rx_count = 0;
    send(ABC, 0, hs);
    repeat (212) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_uart_tx", uart_tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_bytes_before", rx_count, 5);
    exp_q.delete();
    flag_done = 0;
    flag_tx = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) flag_done = 1;
      if (uart_tx !== 1'b1) flag_tx = 1;
    end
    chk("abort_no_done", flag_done, 0);
    chk("abort_line_idle", flag_tx, 0);
    rx_count = 0;
    send(ONE, 0, hs);
    wait_done(0, dc, rs);
    chk("one_latency", dc - hs, 320 * CPB);
    repeat (4) @(negedge clk);
    chk("one_rx_count", rx_count, 32);
    chk("one_queue_drained", exp_q.size(), 0);

    // Back-to-back: valid held high, second digest accepted in the done cycle.
    rx_count = 0;
    send(ABC, 1, hs);
    dif.digest = DB;
    wait_done(0, dc, rs);
    chk("b2b_ready_at_done", dif.digest_ready, 1);
    @(posedge clk); #1;
    hs2 = cyc;
    push_digest(DB);
    dif.digest_valid = 1'b0;
    chk("b2b_handshake_at_done", hs2 - dc, 1);
    @(negedge clk);
    chk("b2b_start_bit", uart_tx, 0);
    wait_done(0, dc2, rs);
    chk("b2b_second_latency", dc2 - hs2, 320 * CPB);
    // From the first start-bit cycle to the edge raising the second done.
    chk("b2b_total", dc2 - (hs + 1), 640 * CPB);
    repeat (4) @(negedge clk);
    chk("b2b_rx_count", rx_count, 64);
    chk("b2b_queue_drained", exp_q.size(), 0);

    // All-zero digest: 32 frames of start, eight zeros, stop.
    rx_count = 0;
    send('0, 0, hs);
    wait_done(0, dc, rs);
    chk("zero_latency", dc - hs, 320 * CPB);
    repeat (50) @(negedge clk);
    chk("zero_rx_count", rx_count, 32);
    chk("zero_queue_drained", exp_q.size(), 0);
    chk("zero_idle_line", uart_tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
